sr_input_conditioner: RTL and testbench
=======================================

Name: sr_input_conditioner

Overview:
- Front-end stage that drives the s/r inputs of the SR latch.
- Synchronises and debounces two raw asynchronous request lines (set, reset) and resolves illegal simultaneous requests.
- Presents clean, registered, mutually exclusive s/r levels to the latch.
- Counts illegal-request events for debug.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised input must differ from its stable value before the stable value updates; legal range 1..255.
- CNT_W, 8: width of the per-channel debounce counters and the conflict event counter.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- s_raw  input  1  raw asynchronous set request.
- r_raw  input  1  raw asynchronous reset request.
- s  output  1  clean set level to the latch.
- r  output  1  clean reset level to the latch.
- conflict  output  1  high while the block is in CONFLICT state.
- conflict_count  output  CNT_W  saturating count of entries into CONFLICT.

Behaviour:
- Reset (reset==0 at an edge): all state clears.
  - s=0, r=0, conflict=0, conflict_count=0.
  - Synchroniser flops and stable values =0; debounce counters =0; FSM=IDLE.
- Synchroniser: 2 flops per channel (x_sync1 -> x_sync2).
- Debounce, per channel:
  - If x_sync2 != x_stable, the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and x_sync2 still differs, x_stable <= x_sync2 and the counter <= 0.
  - If x_sync2 == x_stable, the counter <= 0. A glitch shorter than DEBOUNCE_CYCLES cycles never changes x_stable.
- FSM, registered outputs, evaluated from (s_stable, r_stable):
  - IDLE (s=0,r=0): 10 -> SET; 01 -> RST; 11 -> CONFLICT; 00 -> stay.
  - SET (s=1): 00 -> IDLE; 01 -> RST; 11 -> CONFLICT.
  - RST (r=1): 00 -> IDLE; 10 -> SET; 11 -> CONFLICT.
  - CONFLICT (s=0, r=0, conflict=1): lockout. Stays until stable pair == 00, then -> IDLE. 10/01 while in CONFLICT -> stay.
- s and r are never 1 in the same cycle under any input sequence.
- Latency: a raw level held constant from edge t is reflected on s/r at edge t+DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES debounce + 1 output register); 7 edges at default.
- conflict_count:
  - Increments by 1 on each transition into CONFLICT.
  - Saturates at 2^CNT_W-1.
  - Clears only on reset.
- Reset mid-operation: all counters and in-flight debounce progress are discarded. After release, the input must re-qualify for the full latency.
- Simultaneous stable changes are handled as a pair in the same cycle, e.g. 10 -> 01 goes SET -> RST directly, with no IDLE cycle.

Optional Feature:
- Macro SR_RESET_PRIORITY_EN.
- Defined:
  - Stable pair 11 is treated as a reset request; FSM goes to RST.
  - CONFLICT state is never entered.
  - conflict stays 0.
  - conflict_count still increments on each cycle where the pair transitions into 11 (saturating), as an illegal-request tally.
- Undefined: behaviour exactly as above, including the CONFLICT lockout.

Decomposition:
- Shared package sr_pkg:
  - FSM state typedef {IDLE, SET, RST, CONFLICT}, 2 bits.
  - Default constants DEBOUNCE_CYCLES_DEF=4 and CNT_W_DEF=8.
- One sub-module, sr_debounce_chan: synchroniser, debounce counter and stable output for a single input.
  - Instantiated twice.
  - Parameterised by DEBOUNCE_CYCLES and CNT_W.

Test Plan:
- Reset: hold reset=0 for 3 cycles with s_raw=r_raw=1 -> s=0, r=0, conflict=0, conflict_count=0 throughout; release reset -> first change of s/r no earlier than 7 edges later.
- Clean set: s_raw=1 from edge 10, r_raw=0 -> s=1 exactly at edge 17, r=0; drop s_raw at edge 30 -> s=0 at edge 37.
- Glitch rejection: r_raw pulse of 3 cycles (DEBOUNCE_CYCLES=4) -> r never asserts; a 4-cycle pulse -> r=1 for 4 cycles, beginning 7 edges after the pulse starts.
- Conflict lockout: s_raw=1 qualified (s=1), then r_raw=1 -> conflict=1, s=r=0, conflict_count=1. Drop r_raw only -> stays in CONFLICT. Drop s_raw -> IDLE. Repeat 300 times with CNT_W=8 -> conflict_count saturates at 255.
- Direct swap: s_raw 1->0 and r_raw 0->1 on the same edge while in SET -> s falls and r rises on the same edge, and s&r is never 1.
- With SR_RESET_PRIORITY_EN: both raw inputs held at 1 -> r=1, s=0, conflict=0, conflict_count=1.

Source files
------------

// File: rtl/sr_pkg.sv
// -----------------------------------------------------------------------------
// sr_pkg
// Shared declarations for the SR latch input conditioner:
//   - sr_state_t          : 2-bit conditioner FSM state encoding
//   - DEBOUNCE_CYCLES_DEF : default debounce qualification length in cycles
//   - CNT_W_DEF           : default width of debounce and conflict counters
// -----------------------------------------------------------------------------
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET      = 2'd1,
    RST      = 2'd2,
    CONFLICT = 2'd3
  } sr_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 8;

endpackage : sr_pkg

// File: rtl/sr_debounce_chan.sv
// -----------------------------------------------------------------------------
// sr_debounce_chan
// Two-flop synchroniser followed by a debounce counter for one raw request.
// The stable level only follows the synchronised input after it has differed
// from the current stable level on DEBOUNCE_CYCLES consecutive samples.
//
// Ports:
//   clk    in  1  system clock, rising edge
//   reset  in  1  synchronous active-low reset
//   raw    in  1  raw asynchronous request line
//   stable out 1  debounced, synchronised level
// -----------------------------------------------------------------------------
module sr_debounce_chan
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchroniser, debounce counter and stable level register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= CNT_ZERO;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != stable) begin
        // The sample that finds cnt at its last value is the
        // DEBOUNCE_CYCLES-th consecutive differing sample.
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= CNT_ZERO;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        cnt <= CNT_ZERO;
      end
    end
  end

endmodule : sr_debounce_chan

// File: rtl/sr_input_conditioner.sv
// -----------------------------------------------------------------------------
// sr_input_conditioner
// Conditions the raw set/reset requests that feed the SR latch: each line is
// synchronised and debounced, then a small FSM resolves the stable pair into
// registered, mutually exclusive s/r levels. A simultaneous set+reset request
// locks the block in CONFLICT until both requests are released.
//
// Build option:
//   SR_RESET_PRIORITY_EN - when defined, a stable set+reset pair is resolved
//   as a reset request (no CONFLICT lockout); conflict_count then tallies
//   every cycle in which the stable pair becomes 11.
//
// Ports:
//   clk            in  1      system clock, rising edge
//   reset          in  1      synchronous active-low reset
//   s_raw          in  1      raw asynchronous set request
//   r_raw          in  1      raw asynchronous reset request
//   s              out 1      clean set level
//   r              out 1      clean reset level
//   conflict       out 1      high while in CONFLICT
//   conflict_count out CNT_W  saturating count of illegal-request events
// -----------------------------------------------------------------------------
module sr_input_conditioner
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_raw,
  input  logic             r_raw,
  output logic             s,
  output logic             r,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_count
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic       s_stable;
  logic       r_stable;
  logic [1:0] pair;
  sr_state_t  state;
  sr_state_t  state_next;
  logic       illegal_event;

  sr_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set_chan (
    .clk   (clk),
    .reset (reset),
    .raw   (s_raw),
    .stable(s_stable)
  );

  sr_debounce_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_rst_chan (
    .clk   (clk),
    .reset (reset),
    .raw   (r_raw),
    .stable(r_stable)
  );

  assign pair = {s_stable, r_stable};

`ifdef SR_RESET_PRIORITY_EN
  logic [1:0] pair_prev;

  // Previous stable pair, used to spot the cycle the pair becomes 11.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pair_prev <= 2'b00;
    end else begin
      pair_prev <= pair;
    end
  end
`endif

  // Next-state decode from the stable request pair.
  always_comb begin
    state_next = state;
    case (state)
      CONFLICT: begin
        // Lockout: only a full release of both requests leaves CONFLICT.
        if (pair == 2'b00) begin
          state_next = IDLE;
        end else begin
          state_next = CONFLICT;
        end
      end
      default: begin
        case (pair)
          2'b00:   state_next = IDLE;
          2'b10:   state_next = SET;
          2'b01:   state_next = RST;
          2'b11: begin
`ifdef SR_RESET_PRIORITY_EN
            state_next = RST;
`else
            state_next = CONFLICT;
`endif
          end
          default: state_next = state;
        endcase
      end
    endcase
  end

  // Illegal-request event detection for the debug counter.
  always_comb begin
    illegal_event = 1'b0;
`ifdef SR_RESET_PRIORITY_EN
    if ((pair == 2'b11) && (pair_prev != 2'b11)) begin
      illegal_event = 1'b1;
    end else begin
      illegal_event = 1'b0;
    end
`else
    if ((state_next == CONFLICT) && (state != CONFLICT)) begin
      illegal_event = 1'b1;
    end else begin
      illegal_event = 1'b0;
    end
`endif
  end

  // State register with outputs registered from the next-state decode, so
  // s/r/conflict change on the same edge as the state and s/r stay exclusive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      s              <= 1'b0;
      r              <= 1'b0;
      conflict       <= 1'b0;
      conflict_count <= CNT_ZERO;
    end else begin
      state    <= state_next;
      s        <= (state_next == SET);
      r        <= (state_next == RST);
      conflict <= (state_next == CONFLICT);
      if (illegal_event && (conflict_count != CNT_MAX)) begin
        conflict_count <= conflict_count + CNT_ONE;
      end
    end
  end

endmodule : sr_input_conditioner

// File: tb/tb_sr_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sr_input_conditioner
// Directed self-checking bench for sr_input_conditioner at default parameters
// (DEBOUNCE_CYCLES=4, CNT_W=8). Inputs change 1 time unit after a rising edge;
// a level changed after edge t shows on s/r at edge t+7. Outputs are sampled
// 1 time unit after each rising edge. Expected values follow the build option
// SR_RESET_PRIORITY_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_sr_input_conditioner;

`ifdef SR_RESET_PRIORITY_EN
  localparam logic PRIO = 1'b1;
`else
  localparam logic PRIO = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       s_raw;
  logic       r_raw;
  logic       s;
  logic       r;
  logic       conflict;
  logic [7:0] conflict_count;

  int total;
  int bad;

  sr_input_conditioner dut (
    .clk           (clk),
    .reset         (reset),
    .s_raw         (s_raw),
    .r_raw         (r_raw),
    .s             (s),
    .r             (r),
    .conflict      (conflict),
    .conflict_count(conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    s_raw = 1'b1;
    r_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total++;
      if ({s, r, conflict} !== 3'b000) begin
        bad++;
        $display("FAIL reset_outs cyc=%0d got s/r/c=%b%b%b want 000", i, s, r, conflict);
      end
      total++;
      if (conflict_count !== 8'd0) begin
        bad++;
        $display("FAIL reset_cnt cyc=%0d got %0d want 0", i, conflict_count);
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      total++;
      if ({s, r, conflict} !== 3'b000) begin
        bad++;
        $display("FAIL reset_release_early edge=%0d got s/r/c=%b%b%b want 000", i, s, r, conflict);
      end
    end
    tick(1);
    total++;
    if ({s, r, conflict} !== {1'b0, PRIO, ~PRIO}) begin
      bad++;
      $display("FAIL reset_release_7 got s/r/c=%b%b%b want %b%b%b", s, r, conflict, 1'b0, PRIO, ~PRIO);
    end
    total++;
    if (conflict_count !== 8'd1) begin
      bad++;
      $display("FAIL reset_release_cnt got %0d want 1", conflict_count);
    end
    s_raw = 1'b0;
    r_raw = 1'b0;
    tick(7);
    total++;
    if ({s, r, conflict} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle got s/r/c=%b%b%b want 000", s, r, conflict);
    end
  endtask

  task automatic test_clean_set();
    s_raw = 1'b1;
    tick(6);
    total++;
    if (s !== 1'b0) begin
      bad++;
      $display("FAIL set_early got s=%b want 0", s);
    end
    tick(1);
    total++;
    if ({s, r} !== 2'b10) begin
      bad++;
      $display("FAIL set_rise got s/r=%b%b want 10", s, r);
    end
    tick(6);
    s_raw = 1'b0;
    tick(6);
    total++;
    if (s !== 1'b1) begin
      bad++;
      $display("FAIL set_hold got s=%b want 1", s);
    end
    tick(1);
    total++;
    if (s !== 1'b0) begin
      bad++;
      $display("FAIL set_fall got s=%b want 0", s);
    end
  endtask

  task automatic test_glitch();
    r_raw = 1'b1;
    tick(3);
    r_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      total++;
      if (r !== 1'b0) begin
        bad++;
        $display("FAIL glitch3 cyc=%0d got r=%b want 0", i, r);
      end
    end
    r_raw = 1'b1;
    tick(4);
    r_raw = 1'b0;
    tick(2);
    total++;
    if (r !== 1'b0) begin
      bad++;
      $display("FAIL glitch4_early got r=%b want 0", r);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      total++;
      if ({s, r} !== 2'b01) begin
        bad++;
        $display("FAIL glitch4_high cyc=%0d got s/r=%b%b want 01", i, s, r);
      end
    end
    tick(1);
    total++;
    if (r !== 1'b0) begin
      bad++;
      $display("FAIL glitch4_end got r=%b want 0", r);
    end
    tick(6);
  endtask

  task automatic test_conflict();
    s_raw = 1'b1;
    tick(7);
    total++;
    if (s !== 1'b1) begin
      bad++;
      $display("FAIL conf_pre_set got s=%b want 1", s);
    end
    r_raw = 1'b1;
    tick(7);
    total++;
    if ({s, r, conflict} !== {1'b0, PRIO, ~PRIO}) begin
      bad++;
      $display("FAIL conf_enter got s/r/c=%b%b%b want %b%b%b", s, r, conflict, 1'b0, PRIO, ~PRIO);
    end
    total++;
    if (conflict_count !== 8'd2) begin
      bad++;
      $display("FAIL conf_cnt got %0d want 2", conflict_count);
    end
    r_raw = 1'b0;
    tick(10);
    total++;
    if ({s, r, conflict} !== {PRIO, 1'b0, ~PRIO}) begin
      bad++;
      $display("FAIL conf_lock got s/r/c=%b%b%b want %b%b%b", s, r, conflict, PRIO, 1'b0, ~PRIO);
    end
    s_raw = 1'b0;
    tick(7);
    total++;
    if ({s, r, conflict} !== 3'b000) begin
      bad++;
      $display("FAIL conf_exit got s/r/c=%b%b%b want 000", s, r, conflict);
    end
  endtask

  task automatic test_back_to_back();
    s_raw = 1'b1;
    tick(7);
    total++;
    if (s !== 1'b1) begin
      bad++;
      $display("FAIL swap_pre got s=%b want 1", s);
    end
    s_raw = 1'b0;
    r_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      total++;
      if ((s & r) !== 1'b0) begin
        bad++;
        $display("FAIL swap_excl edge=%0d got s&r=%b want 0", i, s & r);
      end
      if (i == 6) begin
        total++;
        if ({s, r} !== 2'b10) begin
          bad++;
          $display("FAIL swap_before got s/r=%b%b want 10", s, r);
        end
      end
      if (i == 7) begin
        total++;
        if ({s, r} !== 2'b01) begin
          bad++;
          $display("FAIL swap_after got s/r=%b%b want 01", s, r);
        end
      end
    end
    r_raw = 1'b0;
    tick(7);
    total++;
    if ({s, r} !== 2'b00) begin
      bad++;
      $display("FAIL swap_idle got s/r=%b%b want 00", s, r);
    end
  endtask

  task automatic test_reset_mid();
    s_raw = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    total++;
    if ({s, conflict_count} !== {1'b0, 8'd0}) begin
      bad++;
      $display("FAIL mid_reset got s=%b cnt=%0d want s=0 cnt=0", s, conflict_count);
    end
    reset = 1'b1;
    tick(6);
    total++;
    if (s !== 1'b0) begin
      bad++;
      $display("FAIL mid_requal_early got s=%b want 0", s);
    end
    tick(1);
    total++;
    if (s !== 1'b1) begin
      bad++;
      $display("FAIL mid_requal got s=%b want 1", s);
    end
    s_raw = 1'b0;
    tick(7);
    total++;
    if (s !== 1'b0) begin
      bad++;
      $display("FAIL mid_release got s=%b want 0", s);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      s_raw = 1'b1;
      r_raw = 1'b1;
      tick(7);
      if (exp_cnt < 255) exp_cnt++;
      total++;
      if (conflict_count !== 8'(exp_cnt)) begin
        bad++;
        $display("FAIL sat_cnt iter=%0d got %0d want %0d", i, conflict_count, exp_cnt);
      end
      total++;
      if ({r, conflict} !== {PRIO, ~PRIO}) begin
        bad++;
        $display("FAIL sat_state iter=%0d got r/c=%b%b want %b%b", i, r, conflict, PRIO, ~PRIO);
      end
      s_raw = 1'b0;
      r_raw = 1'b0;
      tick(7);
    end
    total++;
    if (conflict_count !== 8'd255) begin
      bad++;
      $display("FAIL sat_final got %0d want 255", conflict_count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    s_raw = 1'b0;
    r_raw = 1'b0;
    test_reset();
    test_clean_set();
    test_glitch();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sr_input_conditioner
